excess3_bcd_seq_ctrl: RTL and testbench

Sequencing controller that converts a packed multi-digit Excess-3 word to packed BCD through a single shared one-digit Excess-3→BCD datapath. It processes one digit per clock, least-significant digit first, and flags illegal Excess-3 codes per digit. Valid/ready handshakes sit on both sides, so the block slots between a code source and a BCD consumer (display driver, adder) in the code-converter chain.

---
 rtl/excess3_bcd_seq_ctrl.sv | 114 +++++++++++
 tb/tb_excess3_bcd_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_bcd_seq_ctrl.sv
// Multi-digit Excess-3 to BCD converter that reuses one digit converter,
// stepping least-significant digit first between valid/ready handshakes.
module excess3_bcd_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [4*DIGITS-1:0] hold_word;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [DIGITS-1:0]   err_reg;
    logic [IW-1:0]       idx;
    logic [3:0]          cur_code;
    logic [3:0]          cur_bcd;
    logic                cur_err;
    logic                accept;
    logic                last_digit;

    always_comb begin
        accept     = in_valid && in_ready;
        last_digit = (idx == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (last_digit) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with rst keeps a word from being taken on a reset edge.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_comb begin
        cur_code = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) cur_code = hold_word[4*i +: 4];
        end
        cur_err = (cur_code < 4'd3) || (cur_code > 4'd12);
        cur_bcd = cur_err ? 4'h0 : (cur_code - 4'd3);
    end

    // Result registers are only written in IDLE/CONV, so DONE holds them
    // stable for as long as the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word <= '0;
            bcd_reg   <= '0;
            err_reg   <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_word <= in_data;
                        bcd_reg   <= '0;
                        err_reg   <= '0;
                        idx       <= '0;
                    end
                end
                CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) begin
                            bcd_reg[4*i +: 4] <= cur_bcd;
                            err_reg[i]        <= cur_err;
                        end
                    end
                    idx <= last_digit ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_bcd      = bcd_reg;
        out_err_mask = err_reg;
        out_err      = |err_reg;
    end

endmodule

// File: tb/tb_excess3_bcd_seq_ctrl.sv
// Randomized self-checking bench for excess3_bcd_seq_ctrl, compared against
// a digit-by-digit arithmetic model of the Excess-3 decoding rules.
module tb_excess3_bcd_seq_ctrl;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_err_mask;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    excess3_bcd_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_err_mask (out_err_mask),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_bcd(input logic [15:0] w);
        int r = 0;
        int d;
        for (int i = 0; i < DIGITS; i++) begin
            d = (int'(w) >> (4 * i)) % 16;
            if (d >= 3 && d <= 12) r += (d - 3) * (1 << (4 * i));
        end
        return 16'(r);
    endfunction

    function automatic logic [3:0] model_mask(input logic [15:0] w);
        int m = 0;
        int d;
        for (int i = 0; i < DIGITS; i++) begin
            d = (int'(w) >> (4 * i)) % 16;
            if (d < 3 || d > 12) m += (1 << i);
        end
        return 4'(m);
    endfunction

    // Presents a word, waits for acceptance, then scrambles in_data while
    // counting edges until out_valid; returns at the negedge it is seen.
    task automatic send_word(input logic [15:0] w, output int lat, output bit timeout);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        timeout = !in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            in_data = 16'($urandom);
            lat++;
        end
        timeout = timeout || !out_valid;
    endtask

    task automatic deliver_word();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        tests++;
        if (out_bcd !== 16'h0 || out_err_mask !== 4'h0 || out_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: bcd=%h mask=%b err=%b, required 0000 0000 0", out_bcd, out_err_mask, out_err);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_fixed(input logic [15:0] w, input string name);
        int lat;
        bit to;
        logic [15:0] exp_bcd = model_bcd(w);
        logic [3:0]  exp_mask = model_mask(w);
        out_ready = 1'b1;
        send_word(w, lat, to);
        tests++;
        if (to || lat !== DIGITS) begin
            fails++;
            $display("[TB] FAIL %s_latency: %0d cycles (timeout=%0d), required %0d", name, lat, to, DIGITS);
        end
        tests++;
        if (out_bcd !== exp_bcd || out_err_mask !== exp_mask || out_err !== (|exp_mask)) begin
            fails++;
            $display("[TB] FAIL %s_result: in=%h bcd=%h mask=%b err=%b, required %h %b %b",
                     name, w, out_bcd, out_err_mask, out_err, exp_bcd, exp_mask, |exp_mask);
        end
        deliver_word();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_return: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        logic [15:0] w;
        for (int k = 0; k < 20; k++) begin
            w = 16'($urandom);
            if (k % 2 == 0) begin
                for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = 4'($urandom_range(3, 12));
            end
            send_word(w, lat, to);
            tests++;
            if (to || lat !== DIGITS || out_bcd !== model_bcd(w) || out_err_mask !== model_mask(w)
                || out_err !== (|model_mask(w))) begin
                fails++;
                $display("[TB] FAIL random_%0d: in=%h lat=%0d bcd=%h mask=%b err=%b, required lat=%0d %h %b %b",
                         k, w, lat, out_bcd, out_err_mask, out_err, DIGITS, model_bcd(w), model_mask(w), |model_mask(w));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            deliver_word();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        logic [15:0] w = 16'h9A3B;
        out_ready = 1'b0;
        send_word(w, lat, to);
        tests++;
        if (to) begin
            fails++;
            $display("[TB] FAIL bp_timeout: out_valid=%b, required 1", out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== model_bcd(w) || out_err_mask !== model_mask(w)) begin
                fails++;
                $display("[TB] FAIL bp_hold_%0d: valid=%b ready=%b bcd=%h mask=%b, required 1 0 %h %b",
                         c, out_valid, in_ready, out_bcd, out_err_mask, model_bcd(w), model_mask(w));
            end
        end
        deliver_word();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_bcd !== 16'h0) begin
            fails++;
            $display("[TB] FAIL midreset_edge: valid=%b ready=%b bcd=%h, required 0 0 0000", out_valid, in_ready, out_bcd);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_ready: in_ready=%b, required 1", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_no_output: out_valid rose=%b, required 0", seen);
        end
        test_fixed(16'h4444, "after_reset");
        tests++;
        if (model_bcd(16'h4444) !== 16'h1111) begin
            fails++;
            $display("[TB] FAIL model_sanity: model=%h, required 1111", model_bcd(16'h4444));
        end
    endtask

    task automatic test_reset_in_done();
        int lat;
        bit to;
        out_ready = 1'b0;
        send_word(16'h4567, lat, to);
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (to || out_valid !== 1'b0 || out_bcd !== 16'h0 || out_err_mask !== 4'h0) begin
            fails++;
            $display("[TB] FAIL done_reset: valid=%b bcd=%h mask=%b, required 0 0000 0000", out_valid, out_bcd, out_err_mask);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3];
        int acc[3];
        int nacc = 0;
        int nout = 0;
        int cyc  = 0;
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = words[0];
        while (nout < 3 && cyc < 100) begin
            if (out_valid) begin
                tests++;
                if (out_bcd !== model_bcd(words[nout]) || out_err_mask !== model_mask(words[nout])) begin
                    fails++;
                    $display("[TB] FAIL b2b_result_%0d: bcd=%h mask=%b, required %h %b",
                             nout, out_bcd, out_err_mask, model_bcd(words[nout]), model_mask(words[nout]));
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                if (nacc < 3) acc[nacc] = cyc;
                nacc++;
            end else if (nacc < 3) begin
                in_valid = 1'b1;
                in_data  = words[nacc];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (nout !== 3 || nacc !== 3) begin
            fails++;
            $display("[TB] FAIL b2b_count: outputs=%0d accepts=%0d, required 3 3", nout, nacc);
        end else begin
            tests++;
            if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
                fails++;
                $display("[TB] FAIL b2b_spacing: gaps %0d %0d, required 6 6", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed(16'h3456, "nominal");
        test_fixed(16'hCBA9, "extreme_high");
        test_fixed(16'h3333, "extreme_low");
        test_fixed(16'h3F43, "illegal_one");
        test_fixed(16'h012D, "illegal_all");
        test_random();
        test_backpressure();
        test_reset_mid();
        test_reset_in_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
